// File: rtl/gcd_arbiter.sv
// ============================================================================
//  Module      : gcd_arbiter
//  Description : Round-robin front end that shares one GCD core between N
//                requesters; zero operands are answered locally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N-1:0]   done,
    output logic [W-1:0]   result,
    output logic           busy,
    output logic           core_start,
    output logic [W-1:0]   core_a,
    output logic [W-1:0]   core_b,
    input  logic           core_ready,
    input  logic [W-1:0]   core_out
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    logic [2:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_gidx;
    logic [W-1:0]  r_opa;
    logic [W-1:0]  r_opb;
    logic [W-1:0]  r_result;

    logic          w_gnt_valid;
    logic [IW-1:0] w_gnt_idx;
    logic [W-1:0]  w_sel_a;
    logic [W-1:0]  w_sel_b;

    // Scan from ptr+N down to ptr+1 so the candidate nearest ptr+1 is written last.
    always_comb begin
        int            idx_int;
        logic [IW-1:0] idx;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        idx_int     = 0;
        idx         = '0;
        for (int k = N; k >= 1; k--) begin
            idx_int = (int'(r_ptr) + k) % N;
            idx     = idx_int[IW-1:0];
            if (req[idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = idx;
            end
        end
    end

    assign w_sel_a = a_in[w_gnt_idx*W +: W];
    assign w_sel_b = b_in[w_gnt_idx*W +: W];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_ptr    <= IW'(N-1);
            r_gidx   <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gidx <= w_gnt_idx;
                        r_ptr  <= w_gnt_idx;
                        r_opa  <= w_sel_a;
                        r_opb  <= w_sel_b;
                        // The core never terminates on a zero operand; gcd(0,x)=x.
                        if (w_sel_a == '0 || w_sel_b == '0) begin
                            r_result <= w_sel_a | w_sel_b;
                            r_state  <= S_RESP;
                        end else begin
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!core_ready) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (core_ready) begin
                        r_result <= core_out;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        done = '0;
        if (r_state == S_RESP) begin
            done[r_gidx] = 1'b1;
        end
    end

    assign result     = r_result;
    assign busy       = (r_state != S_IDLE);
    assign core_start = (r_state == S_ISSUE);
    assign core_a     = r_opa;
    assign core_b     = r_opb;

endmodule

`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
// ============================================================================
//  Module      : tb_gcd_arbiter
//  Description : Self-checking bench for gcd_arbiter with a behavioural core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           nrst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           busy;
    logic           core_start;
    logic [W-1:0]   core_a;
    logic [W-1:0]   core_b;
    logic           core_ready;
    logic [W-1:0]   core_out;

    logic [W-1:0]   a_op [N];
    logic [W-1:0]   b_op [N];

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = N - 1;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = a_op[i];
            b_in[i*W +: W] = b_op[i];
        end
    end

    gcd_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .done       (done),
        .result     (result),
        .busy       (busy),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_ready (core_ready),
        .core_out   (core_out)
    );

    function automatic int gcd_ref(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int rr_pick(logic [N-1:0] r, int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 9) == 0) return '0;
        return W'($urandom_range(1, 255));
    endfunction

    // Behavioural GCD core: ready drops after start, rises after a random run.
    int         starts    = 0;
    int         core_cnt  = 0;
    bit         core_long = 1'b0;
    logic [W-1:0] last_a, last_b;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            core_ready <= 1'b1;
            core_out   <= '0;
            core_cnt   <= 0;
        end else if (core_start && core_ready) begin
            core_ready <= 1'b0;
            core_cnt   <= core_long ? 40 : int'($urandom_range(1, 6));
            last_a     <= core_a;
            last_b     <= core_b;
            starts     <= starts + 1;
        end else if (!core_ready) begin
            if (core_cnt == 1) begin
                core_ready <= 1'b1;
                core_out   <= W'(gcd_ref(int'(last_a), int'(last_b)));
            end
            core_cnt <= core_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        req  = '0;
        nrst = 1'b0;
        #1;
        check("rst_done",   32'(done),       0);
        check("rst_result", 32'(result),     0);
        check("rst_busy",   32'(busy),       0);
        check("rst_start",  32'(core_start), 0);
        check("rst_core_a", 32'(core_a),     0);
        check("rst_core_b", 32'(core_b),     0);
        @(negedge clk);
        @(negedge clk);
        nrst  = 1'b1;
        m_ptr = N - 1;
    endtask

    // Returns at the negedge of the idle cycle following the done pulse.
    task automatic wait_done(output logic [N-1:0] d, output logic [W-1:0] r);
        int cnt = 0;
        while (done == '0 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("done_seen", 32'(done != '0), 1);
        d = done;
        r = result;
        @(negedge clk);
        check("done_1cyc", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    task automatic serve_one(input logic [N-1:0] pend, output int w, output logic [N-1:0] d);
        logic [W-1:0] r;
        wait_done(d, r);
        w = rr_pick(pend, m_ptr);
        check("grant",  32'(d), 32'(1) << w);
        check("result", 32'(r), 32'(gcd_ref(int'(a_op[w]), int'(b_op[w]))));
        m_ptr = w;
    endtask

    task automatic wait_core_low();
        int cnt = 0;
        while (core_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("core_low", 32'(core_ready), 0);
    endtask

    initial begin
        int w;
        int s0;
        logic [N-1:0] d;

        for (int i = 0; i < N; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        do_reset();

        // Single core run
        @(negedge clk);
        a_op[0] = 8'd48; b_op[0] = 8'd18;
        s0  = starts;
        req = 4'b0001;
        serve_one(4'b0001, w, d);
        req = '0;
        check("t1_starts", 32'(starts - s0), 1);
        check("t1_core_a", 32'(last_a), 48);
        check("t1_core_b", 32'(last_b), 18);

        // Two simultaneous requests after reset
        do_reset();
        a_op[0] = 8'd12; b_op[0] = 8'd8;
        a_op[1] = 8'd35; b_op[1] = 8'd14;
        req = 4'b0011;
        serve_one(4'b0011, w, d);
        check("t2_first", 32'(d), 1);
        req = 4'b0010;
        serve_one(4'b0010, w, d);
        check("t2_second", 32'(d), 2);
        req = '0;

        // Zero-operand bypass latency
        a_op[2] = 8'd0; b_op[2] = 8'd25;
        s0  = starts;
        req = 4'b0100;
        @(negedge clk);
        check("t3_byp_done",   32'(done),   4);
        check("t3_byp_result", 32'(result), 25);
        m_ptr = 2;
        req = '0;
        @(negedge clk);
        a_op[2] = 8'd0; b_op[2] = 8'd0;
        req = 4'b0100;
        serve_one(4'b0100, w, d);
        req = '0;
        check("t3_no_start", 32'(starts - s0), 0);

        // Equal operands; req dropped mid-service still completes
        a_op[3] = 8'd9; b_op[3] = 8'd9;
        s0  = starts;
        req = 4'b1000;
        wait_core_low();
        req = '0;
        serve_one(4'b1000, w, d);
        check("t4_starts", 32'(starts - s0), 1);

        // Three held requesters rotate
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a_op[i] = W'($urandom_range(1, 255));
            b_op[i] = W'($urandom_range(1, 255));
        end
        req = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            serve_one(4'b0111, w, d);
            check("t5_order", 32'(d), 32'(1) << (k % 3));
        end
        req = '0;
        @(negedge clk);

        // Randomized traffic against the round-robin model
        for (int i = 0; i < N; i++) begin
            a_op[i] = rnd_op();
            b_op[i] = rnd_op();
        end
        req = N'($urandom_range(1, (1 << N) - 1));
        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] nreq;
            serve_one(req, w, d);
            nreq = req;
            if ($urandom_range(0, 1) == 0) nreq[w] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i != w && !nreq[i] && $urandom_range(0, 2) == 0) begin
                    a_op[i] = rnd_op();
                    b_op[i] = rnd_op();
                    nreq[i] = 1'b1;
                end
            end
            if (nreq == '0) nreq[w] = 1'b1;
            req = nreq;
        end
        req = '0;
        @(negedge clk);

        // Reset during WAIT_DONE
        a_op[0] = 8'd100; b_op[0] = 8'd75;
        core_long = 1'b1;
        req = 4'b0001;
        wait_core_low();
        @(negedge clk);
        check("t6_busy_pre", 32'(busy), 1);
        do_reset();
        core_long = 1'b0;
        a_op[1] = 8'd21; b_op[1] = 8'd6;
        req = 4'b0011;
        serve_one(4'b0011, w, d);
        check("t6_ptr_reset", 32'(d), 1);
        req = 4'b0010;
        serve_one(4'b0010, w, d);
        check("t6_req1", 32'(d), 2);
        req = '0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
